v2f_divmod_seq: RTL and testbench
=================================

// Module: v2f_divmod_seq
// PURPOSE
//   Multi-cycle radix-2 restoring divider producing quotient and remainder together.
//   It is the sequential, parametrised successor to the combinational div/mod primitives.
//   The mapper uses it when a combinational divider would be too large in combinators.
//   Valid/ready handshakes on both input and output so it chains into pipelined datapaths.
// PARAMETERS
//   WIDTH    8  operand/result width in bits (2..32)
//   A_SIGNED 0  1: dividend and divisor are two's complement; 0: unsigned (applies to A and B)
//   B_SIGNED 0  must equal A_SIGNED; mismatch is an elaboration error ($error)
// PORTS
//   CLK        in   1      clock, all state updates on rising edge
//   SRST       in   1      synchronous reset, active-high
//   IN_VALID   in   1      A/B present
//   IN_READY   out  1      unit idle, can accept
//   A          in   WIDTH  dividend
//   B          in   WIDTH  divisor
//   OUT_VALID  out  1      Q/R hold a result
//   OUT_READY  in   1      consumer takes result
//   Q          out  WIDTH  quotient
//   R          out  WIDTH  remainder
//   DBZ        out  1      divide-by-zero flag (only with V2F_DIVMOD_DBZ_EN)
// BEHAVIOUR
//   One clock (CLK); reset is synchronous and active-high (SRST).
//   SRST: state IDLE, IN_READY=1, OUT_VALID=0, Q=0, R=0, DBZ=0, counter=0.
//   SRST has priority over all other inputs on the same edge.
//   FSM states IDLE -> RUN -> DONE -> IDLE.
//   IDLE: IN_READY=1. On IN_VALID&IN_READY, capture |A|, |B|, and the result signs.
//     Signs: quotient sign = sA^sB, remainder sign = sA; both are 0 when unsigned.
//     Then go to RUN with counter=WIDTH.
//   RUN: IN_READY=0. One quotient bit per cycle, MSB first:
//     shift (rem,dvd) left 1; if rem>=|B| then rem-=|B| and the quotient bit is 1.
//     Internal rem is WIDTH+1 bits. Counter decrements each cycle; at 1, go to DONE.
//   DONE: Q and R sign-corrected and registered; OUT_VALID=1; IN_READY=0.
//     Q/R/DBZ stay stable while OUT_VALID&!OUT_READY.
//     On OUT_READY, go to IDLE and drop OUT_VALID next cycle.
//   Latency: OUT_VALID rises exactly WIDTH+1 cycles after the accepting edge.
//   Throughput: one op per WIDTH+2 cycles at best. No accept in the DONE cycle,
//     so there is no simultaneous accept/retire.
//   Semantics: truncating division toward zero; remainder takes the dividend's sign;
//     A == Q*B + R always holds (mod 2^WIDTH).
//   Signed overflow: MIN / -1 gives Q=MIN (wrap), R=0.
//   Divide by zero: Q = all ones, R = A (raw input bits), latency unchanged.
//   Q/R keep their last result after retire until the next DONE; they are not cleared.
//   IN_VALID while busy: ignored. The producer must hold IN_VALID; no input is lost.
//   SRST mid-RUN or mid-DONE: the operation is discarded and no OUT_VALID follows.
// CONFIGURATION
//   `V2F_DIVMOD_DBZ_EN defined:
//     adds the DBZ port.
//     B==0 takes a fast path IDLE -> DONE, with OUT_VALID one cycle after accept and DBZ=1.
//     DBZ is cleared on the next accept.
//   Not defined: no DBZ port; B==0 takes the full WIDTH+1 latency with the result above.
// TESTING (WIDTH=8 unless noted)
//   unsigned 100/7 -> Q=14, R=2, OUT_VALID exactly 9 cycles after accept
//   A_SIGNED=1: -7/2 -> Q=0xFD (-3), R=0xFF (-1); 7/-2 -> Q=0xFD, R=0x01
//   A_SIGNED=1: -128/-1 -> Q=0x80, R=0x00; unsigned 255/1 -> Q=255, R=0
//   5/0 -> Q=0xFF, R=0x05; with V2F_DIVMOD_DBZ_EN: DBZ=1 and OUT_VALID after 1 cycle
//   OUT_READY low for 5 cycles in DONE -> Q/R stable, IN_READY=0;
//     back-to-back ops spaced WIDTH+2 cycles
//   SRST asserted at RUN cycle 4 -> next cycle IN_READY=1, OUT_VALID=0, Q=R=0;
//     no stale OUT_VALID later

Source files
------------

// File: rtl/v2f_divmod_seq.sv
// Sequential radix-2 restoring divider: quotient and remainder, valid/ready in and out.
// Optional `V2F_DIVMOD_DBZ_EN adds a DBZ flag and a one-cycle divide-by-zero path.
//
// state  | meaning
// -------+------------------------------------------------------------
// S_IDLE | ready for a new operand pair
// S_RUN  | producing one quotient bit per cycle, MSB first
// S_DONE | sign-corrected Q/R held, OUT_VALID high until OUT_READY

module v2f_divmod_seq #(
    parameter int WIDTH    = 8,
    parameter int A_SIGNED = 0,
    parameter int B_SIGNED = 0
) (
    input  logic             CLK,
    input  logic             SRST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R
`ifdef V2F_DIVMOD_DBZ_EN
    ,
    output logic             DBZ
`endif
);

    localparam int CW = $clog2(WIDTH + 1);

    generate
        if (A_SIGNED != B_SIGNED) begin : g_sign_mismatch
            $error("v2f_divmod_seq: A_SIGNED and B_SIGNED must be equal");
        end
        if (WIDTH < 2 || WIDTH > 32) begin : g_width_range
            $error("v2f_divmod_seq: WIDTH must be in 2..32");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [WIDTH:0]   rem;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dvs;
    logic [CW-1:0]    cnt;
    logic             q_neg;
    logic             r_neg;
    logic             b_zero;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] r_reg;

    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;
    logic             b_is_zero;
    logic             zero_fast;
    logic             last;
    logic [WIDTH+1:0] shifted;
    logic             take;
    logic [WIDTH:0]   rem_step;
    logic [WIDTH-1:0] dvd_step;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;

    always_comb begin
        a_neg     = (A_SIGNED != 0) && A[WIDTH-1];
        b_neg     = (B_SIGNED != 0) && B[WIDTH-1];
        a_abs     = a_neg ? (~A + 1'b1) : A;
        b_abs     = b_neg ? (~B + 1'b1) : B;
        b_is_zero = (B == '0);
        last      = (cnt == CW'(1));
    end

`ifdef V2F_DIVMOD_DBZ_EN
    assign zero_fast = b_is_zero;
`else
    assign zero_fast = 1'b0;
`endif

    // One restoring step; the kept remainder is always below the divisor.
    always_comb begin
        shifted  = {rem, dvd[WIDTH-1]};
        take     = (shifted >= {2'b00, dvs});
        rem_step = take ? (WIDTH + 1)'(shifted - {2'b00, dvs}) : shifted[WIDTH:0];
        dvd_step = {dvd[WIDTH-2:0], take};
        q_fix    = q_neg ? (~dvd_step + 1'b1) : dvd_step;
        r_fix    = r_neg ? (~rem_step[WIDTH-1:0] + 1'b1) : rem_step[WIDTH-1:0];
    end

    always_ff @(posedge CLK) begin
        if (SRST) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (IN_VALID) begin
                    state_nxt = zero_fast ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (last) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (OUT_READY) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

`ifdef V2F_DIVMOD_DBZ_EN
    logic dbz_reg;
`endif

    always_ff @(posedge CLK) begin
        if (SRST) begin
            rem    <= '0;
            dvd    <= '0;
            dvs    <= '0;
            cnt    <= '0;
            q_neg  <= 1'b0;
            r_neg  <= 1'b0;
            b_zero <= 1'b0;
            q_reg  <= '0;
            r_reg  <= '0;
`ifdef V2F_DIVMOD_DBZ_EN
            dbz_reg <= 1'b0;
`endif
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (IN_VALID) begin
                        rem    <= '0;
                        dvd    <= a_abs;
                        dvs    <= b_abs;
                        cnt    <= CW'(WIDTH);
                        q_neg  <= a_neg ^ b_neg;
                        r_neg  <= a_neg;
                        b_zero <= b_is_zero;
`ifdef V2F_DIVMOD_DBZ_EN
                        dbz_reg <= b_is_zero;
                        if (b_is_zero) begin
                            q_reg <= '1;
                            r_reg <= A;
                        end
`endif
                    end
                end
                S_RUN: begin
                    rem <= rem_step;
                    dvd <= dvd_step;
                    cnt <= cnt - 1'b1;
                    if (last) begin
                        // With a zero divisor every step subtracts nothing, so the
                        // sign-restored remainder is the raw dividend; only Q needs forcing.
                        q_reg <= b_zero ? '1 : q_fix;
                        r_reg <= r_fix;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign IN_READY  = (state == S_IDLE);
    assign OUT_VALID = (state == S_DONE);
    assign Q         = q_reg;
    assign R         = r_reg;
`ifdef V2F_DIVMOD_DBZ_EN
    assign DBZ       = dbz_reg;
`endif

endmodule

// File: tb/tb_v2f_divmod_seq.sv
// Directed bench for v2f_divmod_seq: one unsigned and one signed instance on shared inputs.
module tb_v2f_divmod_seq;

    localparam int W = 8;
`ifdef V2F_DIVMOD_DBZ_EN
    localparam int DBZ_LAT = 1;
`else
    localparam int DBZ_LAT = W + 1;
`endif

    logic         CLK = 1'b0;
    logic         srst;
    logic         in_valid;
    logic         out_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         u_in_ready, u_out_valid, s_in_ready, s_out_valid;
    logic [W-1:0] u_q, u_r, s_q, s_r;
`ifdef V2F_DIVMOD_DBZ_EN
    logic         u_dbz, s_dbz;
`endif

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    v2f_divmod_seq #(.WIDTH(W), .A_SIGNED(0), .B_SIGNED(0)) u_dut (
        .CLK(CLK), .SRST(srst), .IN_VALID(in_valid), .IN_READY(u_in_ready),
        .A(a), .B(b), .OUT_VALID(u_out_valid), .OUT_READY(out_ready),
        .Q(u_q), .R(u_r)
`ifdef V2F_DIVMOD_DBZ_EN
        , .DBZ(u_dbz)
`endif
    );

    v2f_divmod_seq #(.WIDTH(W), .A_SIGNED(1), .B_SIGNED(1)) s_dut (
        .CLK(CLK), .SRST(srst), .IN_VALID(in_valid), .IN_READY(s_in_ready),
        .A(a), .B(b), .OUT_VALID(s_out_valid), .OUT_READY(out_ready),
        .Q(s_q), .R(s_r)
`ifdef V2F_DIVMOD_DBZ_EN
        , .DBZ(s_dbz)
`endif
    );

    // Present one operand pair, wait for accept, then count cycles until OUT_VALID.
    // Returns at the negedge where OUT_VALID is first seen (lat = 1 is the cycle after accept).
    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, output int lat);
        int n;
        @(negedge CLK);
        a = av; b = bv; in_valid = 1'b1; out_ready = 1'b0;
        n = 0;
        while (!u_in_ready && n < 50) begin
            @(negedge CLK);
            n++;
        end
        @(negedge CLK);
        in_valid = 1'b0;
        lat = 1;
        while (!u_out_valid && lat < 40) begin
            @(negedge CLK);
            lat++;
        end
    endtask

    task automatic retire();
        out_ready = 1'b1;
        @(negedge CLK);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        srst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
        repeat (3) @(negedge CLK);
        srst = 1'b0;
        checks++; if (u_in_ready !== 1'b1) begin failures++; $display("FAIL reset_u_in_ready got=%b exp=1", u_in_ready); end
        checks++; if (u_out_valid !== 1'b0) begin failures++; $display("FAIL reset_u_out_valid got=%b exp=0", u_out_valid); end
        checks++; if (u_q !== 8'h00) begin failures++; $display("FAIL reset_u_q got=%0h exp=0", u_q); end
        checks++; if (u_r !== 8'h00) begin failures++; $display("FAIL reset_u_r got=%0h exp=0", u_r); end
        checks++; if (s_in_ready !== 1'b1 || s_out_valid !== 1'b0) begin
            failures++; $display("FAIL reset_s_hs got=%b%b exp=10", s_in_ready, s_out_valid);
        end
`ifdef V2F_DIVMOD_DBZ_EN
        checks++; if (u_dbz !== 1'b0) begin failures++; $display("FAIL reset_dbz got=%b exp=0", u_dbz); end
`endif
    endtask

    task automatic test_unsigned();
        logic [W-1:0] ta [3] = '{8'd100, 8'd255, 8'd200};
        logic [W-1:0] tb [3] = '{8'd7,   8'd1,   8'd13};
        logic [W-1:0] tq [3] = '{8'd14,  8'd255, 8'd15};
        logic [W-1:0] tr [3] = '{8'd2,   8'd0,   8'd5};
        int lat;
        for (int i = 0; i < 3; i++) begin
            run_op(ta[i], tb[i], lat);
            checks++; if (lat !== W + 1) begin failures++; $display("FAIL unsigned_latency[%0d] got=%0d exp=%0d", i, lat, W + 1); end
            checks++; if (u_q !== tq[i]) begin failures++; $display("FAIL unsigned_q[%0d] got=%0d exp=%0d", i, u_q, tq[i]); end
            checks++; if (u_r !== tr[i]) begin failures++; $display("FAIL unsigned_r[%0d] got=%0d exp=%0d", i, u_r, tr[i]); end
            retire();
        end
        checks++; if (u_out_valid !== 1'b0 || u_in_ready !== 1'b1) begin
            failures++; $display("FAIL unsigned_retire got=%b%b exp=01", u_out_valid, u_in_ready);
        end
        checks++; if (u_q !== 8'd15 || u_r !== 8'd5) begin
            failures++; $display("FAIL unsigned_hold_after_retire got=%0d/%0d exp=15/5", u_q, u_r);
        end
    endtask

    task automatic test_signed();
        logic [W-1:0] ta [4] = '{8'hF9, 8'h07, 8'h80, 8'h81};
        logic [W-1:0] tb [4] = '{8'h02, 8'hFE, 8'hFF, 8'h05};
        logic [W-1:0] sq [4] = '{8'hFD, 8'hFD, 8'h80, 8'hE7};
        logic [W-1:0] sr [4] = '{8'hFF, 8'h01, 8'h00, 8'hFE};
        logic [W-1:0] uq [4] = '{8'h7C, 8'h00, 8'h00, 8'h19};
        logic [W-1:0] ur [4] = '{8'h01, 8'h07, 8'h80, 8'h04};
        int lat;
        for (int i = 0; i < 4; i++) begin
            run_op(ta[i], tb[i], lat);
            checks++; if (s_out_valid !== 1'b1) begin failures++; $display("FAIL signed_valid[%0d] got=%b exp=1", i, s_out_valid); end
            checks++; if (s_q !== sq[i]) begin failures++; $display("FAIL signed_q[%0d] got=%0h exp=%0h", i, s_q, sq[i]); end
            checks++; if (s_r !== sr[i]) begin failures++; $display("FAIL signed_r[%0d] got=%0h exp=%0h", i, s_r, sr[i]); end
            checks++; if (u_q !== uq[i] || u_r !== ur[i]) begin
                failures++; $display("FAIL signed_as_unsigned[%0d] got=%0h/%0h exp=%0h/%0h", i, u_q, u_r, uq[i], ur[i]);
            end
            retire();
        end
    endtask

    task automatic test_div_zero();
        logic [W-1:0] ta [2] = '{8'h05, 8'hFB};
        int lat;
        for (int i = 0; i < 2; i++) begin
            run_op(ta[i], 8'h00, lat);
            checks++; if (lat !== DBZ_LAT) begin failures++; $display("FAIL dbz_latency[%0d] got=%0d exp=%0d", i, lat, DBZ_LAT); end
            checks++; if (u_q !== 8'hFF || u_r !== ta[i]) begin
                failures++; $display("FAIL dbz_unsigned[%0d] got=%0h/%0h exp=ff/%0h", i, u_q, u_r, ta[i]);
            end
            checks++; if (s_q !== 8'hFF || s_r !== ta[i]) begin
                failures++; $display("FAIL dbz_signed[%0d] got=%0h/%0h exp=ff/%0h", i, s_q, s_r, ta[i]);
            end
`ifdef V2F_DIVMOD_DBZ_EN
            checks++; if (u_dbz !== 1'b1 || s_dbz !== 1'b1) begin
                failures++; $display("FAIL dbz_flag[%0d] got=%b%b exp=11", i, u_dbz, s_dbz);
            end
`endif
            retire();
        end
`ifdef V2F_DIVMOD_DBZ_EN
        run_op(8'd10, 8'd3, lat);
        checks++; if (u_dbz !== 1'b0) begin failures++; $display("FAIL dbz_cleared got=%b exp=0", u_dbz); end
        checks++; if (u_q !== 8'd3 || u_r !== 8'd1) begin failures++; $display("FAIL dbz_next_op got=%0d/%0d exp=3/1", u_q, u_r); end
        retire();
`endif
    endtask

    task automatic test_stall();
        int lat;
        run_op(8'd100, 8'd7, lat);
        a = 8'd3; b = 8'd1; in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge CLK);
            checks++; if (u_out_valid !== 1'b1) begin failures++; $display("FAIL stall_valid[%0d] got=%b exp=1", k, u_out_valid); end
            checks++; if (u_in_ready !== 1'b0) begin failures++; $display("FAIL stall_in_ready[%0d] got=%b exp=0", k, u_in_ready); end
            checks++; if (u_q !== 8'd14 || u_r !== 8'd2) begin
                failures++; $display("FAIL stall_qr[%0d] got=%0d/%0d exp=14/2", k, u_q, u_r);
            end
        end
        in_valid = 1'b0;
        retire();
        checks++; if (u_in_ready !== 1'b1 || u_out_valid !== 1'b0) begin
            failures++; $display("FAIL stall_release got=%b%b exp=10", u_in_ready, u_out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] ta [3] = '{8'd100, 8'd50, 8'd9};
        logic [W-1:0] tb [3] = '{8'd7,   8'd6,  8'd3};
        logic [W-1:0] tq [3] = '{8'd14,  8'd8,  8'd3};
        logic [W-1:0] tr [3] = '{8'd2,   8'd2,  8'd0};
        int acc [3] = '{0, 0, 0};
        int nacc = 0;
        int nres = 0;
        logic change = 1'b0;
        @(negedge CLK);
        a = ta[0]; b = tb[0]; in_valid = 1'b1; out_ready = 1'b1;
        for (int k = 0; k < 80 && nres < 3; k++) begin
            if (u_out_valid && nres < 3) begin
                checks++; if (u_q !== tq[nres] || u_r !== tr[nres]) begin
                    failures++; $display("FAIL b2b_qr[%0d] got=%0d/%0d exp=%0d/%0d", nres, u_q, u_r, tq[nres], tr[nres]);
                end
                nres++;
            end
            if (change) begin
                change = 1'b0;
                if (nacc < 3) begin a = ta[nacc]; b = tb[nacc]; end
                else in_valid = 1'b0;
            end
            if (u_in_ready && in_valid && nacc < 3) begin
                acc[nacc] = cyc;
                nacc++;
                change = 1'b1;
            end
            @(negedge CLK);
        end
        in_valid = 1'b0; out_ready = 1'b0;
        checks++; if (nres !== 3) begin failures++; $display("FAIL b2b_results got=%0d exp=3", nres); end
        checks++; if (acc[1] - acc[0] !== W + 2) begin failures++; $display("FAIL b2b_spacing0 got=%0d exp=%0d", acc[1] - acc[0], W + 2); end
        checks++; if (acc[2] - acc[1] !== W + 2) begin failures++; $display("FAIL b2b_spacing1 got=%0d exp=%0d", acc[2] - acc[1], W + 2); end
    endtask

    task automatic test_reset_mid_run();
        int n = 0;
        int stale = 0;
        @(negedge CLK);
        a = 8'd100; b = 8'd7; in_valid = 1'b1;
        while (!u_in_ready && n < 50) begin
            @(negedge CLK);
            n++;
        end
        @(negedge CLK);
        in_valid = 1'b0;
        repeat (3) @(negedge CLK);
        checks++; if (u_in_ready !== 1'b0 || u_out_valid !== 1'b0) begin
            failures++; $display("FAIL midrun_busy got=%b%b exp=00", u_in_ready, u_out_valid);
        end
        srst = 1'b1;
        @(negedge CLK);
        srst = 1'b0;
        checks++; if (u_in_ready !== 1'b1 || u_out_valid !== 1'b0) begin
            failures++; $display("FAIL midrun_reset_hs got=%b%b exp=10", u_in_ready, u_out_valid);
        end
        checks++; if (u_q !== 8'h00 || u_r !== 8'h00) begin
            failures++; $display("FAIL midrun_reset_qr got=%0h/%0h exp=0/0", u_q, u_r);
        end
        checks++; if (s_q !== 8'h00 || s_r !== 8'h00) begin
            failures++; $display("FAIL midrun_reset_sqr got=%0h/%0h exp=0/0", s_q, s_r);
        end
        for (int k = 0; k < 15; k++) begin
            @(negedge CLK);
            if (u_out_valid || s_out_valid) stale++;
        end
        checks++; if (stale !== 0) begin failures++; $display("FAIL midrun_stale_valid got=%0d exp=0", stale); end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_stall();
        test_back_to_back();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
